// File: rtl/iir_pole_mac_sched.sv
`default_nettype none
// ============================================================================
// iir_pole_mac_sched : IIR pole-section scheduler sharing one 12x12 multiplier
// rev 1.0
// ============================================================================
module iir_pole_mac_sched #(
  parameter logic signed [11:0] COE1 = -12'sd922,
  parameter logic signed [11:0] COE2 = 12'sd1163,
  parameter logic signed [11:0] COE3 = -12'sd811,
  parameter logic signed [11:0] COE4 = 12'sd412,
  parameter logic signed [11:0] COE5 = -12'sd122,
  parameter logic signed [11:0] COE6 = 12'sd24,
  parameter logic signed [11:0] COE7 = -12'sd2,
  parameter int                 NTAP = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  input  logic signed [11:0] i_y_in,
  output logic               o_in_ready,
  output logic signed [11:0] o_mul_a,
  output logic signed [11:0] o_mul_b,
  input  logic signed [22:0] i_mul_p,
  output logic signed [25:0] o_yout,
  output logic               o_out_valid,
  input  logic               i_coe_we,
  input  logic [2:0]         i_coe_addr,
  input  logic signed [11:0] i_coe_wdata,
  input  logic               i_ovr_clr,
  output logic               o_overrun,
  output logic               o_cfg_err
);

  localparam logic [2:0] c_LAST_TAP = 3'(NTAP - 1);
  localparam logic signed [11:0] c_COE_DEF [NTAP] = '{COE1, COE2, COE3, COE4, COE5, COE6, COE7};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]         r_tap;
  logic signed [11:0] r_hist [NTAP];
  logic signed [11:0] r_coe  [NTAP];
  logic signed [25:0] r_acc;
  logic signed [25:0] r_yout;
  logic               r_out_valid;
  logic               r_overrun;
  logic               r_cfg_err;

  logic               w_accept;
  logic               w_last;
  logic               w_idle;
  logic               w_coe_wr;
  logic [2:0]         w_coe_idx;
  logic signed [11:0] w_mul_a;
  logic signed [11:0] w_mul_b;
  logic signed [25:0] w_p_ext;
  logic signed [25:0] w_sum;

  assign w_idle    = (r_state == S_IDLE);
  assign w_coe_wr  = i_coe_we && w_idle && (i_coe_addr != 3'd0);
  assign w_coe_idx = i_coe_addr - 3'd1;
  assign w_p_ext   = {{3{i_mul_p[22]}}, i_mul_p};
  assign w_sum     = r_acc + w_p_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_mul_a     = '0;
    w_mul_b     = '0;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        w_mul_a = r_coe[r_tap];
        w_mul_b = r_hist[r_tap];
        if (r_tap == c_LAST_TAP) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap       <= '0;
      r_acc       <= '0;
      r_yout      <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_cfg_err   <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        r_hist[k] <= '0;
        r_coe[k]  <= c_COE_DEF[k];
      end
    end else begin
      r_out_valid <= w_last;

      // The write lands before the MAC pass reads it, so a write on the accept edge is used.
      if (w_coe_wr) begin
        r_coe[w_coe_idx] <= i_coe_wdata;
      end

      if (w_accept) begin
        for (int k = NTAP - 1; k > 0; k--) begin
          r_hist[k] <= r_hist[k-1];
        end
        r_hist[0] <= i_y_in;
        r_acc     <= '0;
        r_tap     <= '0;
      end else if (!w_idle) begin
        r_acc <= w_sum;
        r_tap <= r_tap + 3'd1;
      end

      if (w_last) begin
        r_yout <= w_sum;
      end

      if (i_in_valid && !w_idle) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end

      if (i_coe_we && !w_idle) begin
        r_cfg_err <= 1'b1;
      end else if (i_ovr_clr) begin
        r_cfg_err <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_idle;
  assign o_mul_a     = w_mul_a;
  assign o_mul_b     = w_mul_b;
  assign o_yout      = r_yout;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;
  assign o_cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_iir_pole_mac_sched.sv
`default_nettype none
// ============================================================================
// tb_iir_pole_mac_sched : bench for the IIR pole MAC scheduler
// rev 1.0
// ============================================================================
module tb_iir_pole_mac_sched;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [11:0] y_in = '0;
  logic               coe_we = 1'b0;
  logic [2:0]         coe_addr = '0;
  logic signed [11:0] coe_wdata = '0;
  logic               ovr_clr = 1'b0;

  logic               in_ready;
  logic signed [11:0] mul_a;
  logic signed [11:0] mul_b;
  logic signed [22:0] mul_p;
  logic signed [23:0] prod;
  logic signed [25:0] yout;
  logic               out_valid;
  logic               overrun;
  logic               cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External multiplier: combinational signed product, low 23 bits.
  assign prod  = mul_a * mul_b;
  assign mul_p = prod[22:0];

  iir_pole_mac_sched dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid),
    .i_y_in      (y_in),
    .o_in_ready  (in_ready),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_p     (mul_p),
    .o_yout      (yout),
    .o_out_valid (out_valid),
    .i_coe_we    (coe_we),
    .i_coe_addr  (coe_addr),
    .i_coe_wdata (coe_wdata),
    .i_ovr_clr   (ovr_clr),
    .o_overrun   (overrun),
    .o_cfg_err   (cfg_err)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int     m_coe  [7];
  int     m_hist [7];
  int     m_cnt;
  longint m_pend;
  longint m_yout;
  bit     m_ov, m_ovr, m_cfg, m_live = 1'b0, m_idle;

  function automatic int def_coe(input int k);
    case (k)
      0: return -922;
      1: return 1163;
      2: return -811;
      3: return 412;
      4: return -122;
      5: return 24;
      default: return -2;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) begin
        m_coe[k]  = def_coe(k);
        m_hist[k] = 0;
      end
      m_cnt = 0; m_pend = 0; m_yout = 0;
      m_ov = 0; m_ovr = 0; m_cfg = 0; m_live = 1;
    end else if (m_live) begin
      m_idle = (m_cnt == 0);
      m_ov   = 0;
      if (in_valid && !m_idle) m_ovr = 1; else if (ovr_clr) m_ovr = 0;
      if (coe_we && !m_idle)   m_cfg = 1; else if (ovr_clr) m_cfg = 0;
      if (m_idle) begin
        if (coe_we && coe_addr != 0) m_coe[int'(coe_addr) - 1] = int'(coe_wdata);
        if (in_valid) begin
          for (int k = 6; k > 0; k--) m_hist[k] = m_hist[k-1];
          m_hist[0] = int'(y_in);
          m_pend = 0;
          for (int k = 0; k < 7; k++) m_pend += longint'(m_coe[k]) * m_hist[k];
          m_cnt = 7;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_yout = m_pend;
          m_ov   = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready",  longint'(in_ready),  longint'(m_cnt == 0));
      chk("out_valid", longint'(out_valid), longint'(m_ov));
      chk("yout",      longint'(yout),      m_yout);
      chk("overrun",   longint'(overrun),   longint'(m_ovr));
      chk("cfg_err",   longint'(cfg_err),   longint'(m_cfg));
      chk("mul_a",     longint'(mul_a),     (m_cnt != 0) ? longint'(m_coe[7 - m_cnt])  : 64'sd0);
      chk("mul_b",     longint'(mul_b),     (m_cnt != 0) ? longint'(m_hist[7 - m_cnt]) : 64'sd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; in_valid = 0; coe_we = 0; ovr_clr = 0;
    tick; tick;
    rst = 0;
  endtask

  task automatic wait_out(output longint res, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    res = longint'(yout);
  endtask

  task automatic send(input int y, output longint res, output int lat);
    in_valid = 1; y_in = 12'(y);
    tick;
    in_valid = 0;
    wait_out(res, lat);
  endtask

  initial begin
    longint res;
    int     lat;
    int     pulses;
    longint imp_exp [8];
    imp_exp = '{-922, 1163, -811, 412, -122, 24, -2, 0};

    // Reset state
    do_reset;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_yout",     longint'(yout), 0);
    chk("rst_overrun",  longint'(overrun), 0);
    chk("rst_mul_a",    longint'(mul_a), 0);

    // Impulse response
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 1 : 0, res, lat);
      chk($sformatf("impulse_%0d", i), res, imp_exp[i]);
      if (i == 0) chk("latency", lat, 7);
    end

    // Full-scale negative input
    do_reset;
    for (int i = 0; i < 7; i++) send(-2048, res, lat);
    chk("full_scale", res, 528384);

    // Back-to-back with in_valid held high
    do_reset;
    pulses = 0;
    in_valid = 1;
    for (int i = 0; i < 64; i++) begin
      y_in = 12'($urandom);
      tick;
      if (out_valid) pulses++;
    end
    in_valid = 0;
    chk("b2b_pulses", pulses, 8);

    // Overrun: sample offered 3 clocks after accept is dropped
    do_reset;
    in_valid = 1; y_in = 12'sd5;
    tick;
    in_valid = 0;
    tick; tick;
    in_valid = 1; y_in = 12'sd999;
    tick;
    in_valid = 0;
    chk("overrun_set", longint'(overrun), 1);
    wait_out(res, lat);
    chk("overrun_yout", res, -4610);
    send(0, res, lat);
    chk("overrun_hist", res, 5815);
    ovr_clr = 1; tick; ovr_clr = 0;
    chk("overrun_clr", longint'(overrun), 0);

    // Config write on the accept edge, then a write while busy
    do_reset;
    coe_we = 1; coe_addr = 3'd1; coe_wdata = 12'sd100;
    in_valid = 1; y_in = 12'sd1;
    tick;
    coe_we = 0; in_valid = 0;
    wait_out(res, lat);
    chk("cfg_write", res, 100);
    in_valid = 1; y_in = 12'sd0;
    tick;
    in_valid = 0;
    coe_we = 1; coe_addr = 3'd2; coe_wdata = 12'sd7;
    tick;
    coe_we = 0;
    chk("cfg_err_set", longint'(cfg_err), 1);
    wait_out(res, lat);
    chk("cfg_ignored", res, 1163);

    // Reset at tap 3 restores coefficient defaults
    do_reset;
    coe_we = 1; coe_addr = 3'd1; coe_wdata = 12'sd55;
    tick;
    coe_we = 0;
    in_valid = 1; y_in = 12'sd1;
    tick;
    in_valid = 0;
    tick; tick; tick;
    rst = 1; tick; rst = 0;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_yout",      longint'(yout), 0);
    chk("midrst_in_ready",  longint'(in_ready), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid) pulses++;
    end
    chk("midrst_no_pulse", pulses, 0);
    send(1, res, lat);
    chk("midrst_coe1", res, -922);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      y_in      = 12'($urandom);
      coe_we    = ($urandom_range(0, 15) == 0);
      coe_addr  = 3'($urandom_range(0, 7));
      coe_wdata = 12'($signed($urandom_range(0, 4094)) - 2047);
      ovr_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick;
    end
    rst = 0; in_valid = 0; coe_we = 0; ovr_clr = 0;
    for (int i = 0; i < 10; i++) tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
